// File: rtl/rst_seq_gen.sv
// Multi-channel reset sequencer: releases P_NUM_CH active-high resets in order after a hold
// period, with soft-reset re-sequencing and done/busy status. All outputs registered.
module rst_seq_gen #(
    parameter int P_NUM_CH              = 4,
    parameter int P_NUM_CLK_RST_RELEASE = 100,
    parameter int P_CH_GAP              = 16,
    parameter int P_SRST_MIN            = 8
) (
    input  logic                clk_i,
    input  logic                rsth_i,
    input  logic                en_i,
    input  logic                srst_req_i,
    output logic [P_NUM_CH-1:0] rsth_o,
    output logic                done_o,
    output logic                busy_o
);

    localparam int MAX_A = (P_NUM_CLK_RST_RELEASE > P_CH_GAP) ? P_NUM_CLK_RST_RELEASE : P_CH_GAP;
    localparam int MAX_V = (MAX_A > P_SRST_MIN) ? MAX_A : P_SRST_MIN;
    localparam int CW    = $clog2(MAX_V + 1);
    localparam int IW    = $clog2(P_NUM_CH + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(P_NUM_CLK_RST_RELEASE - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((P_CH_GAP > 0) ? P_CH_GAP - 1 : 0);
    localparam logic [CW-1:0] SRST_LAST = CW'(P_SRST_MIN - 1);
    localparam logic [IW-1:0] LAST_CH   = IW'(P_NUM_CH - 1);

    // With no gap (or a single channel) the first release is also the last one.
    localparam bit                  ALL_AT_ONCE = (P_CH_GAP == 0) || (P_NUM_CH == 1);
    localparam logic [P_NUM_CH-1:0] FIRST_RST   = ALL_AT_ONCE ? '0 : ~P_NUM_CH'(1);

    typedef enum logic [2:0] {S_OFF, S_HOLD, S_SEQ, S_RUN, S_SRST} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [IW-1:0]       ch_idx, ch_n;
    logic [P_NUM_CH-1:0] rst_nxt;
    logic                done_n, busy_n;

    always_ff @(posedge clk_i) begin
        if (rsth_i) begin
            state  <= S_OFF;
            cnt    <= '0;
            ch_idx <= '0;
            rsth_o <= '1;
            done_o <= 1'b0;
            busy_o <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            ch_idx <= ch_n;
            rsth_o <= rst_nxt;
            done_o <= done_n;
            busy_o <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ch_n    = ch_idx;
        rst_nxt = rsth_o;
        unique case (state)
            S_OFF: begin
                if (en_i) begin
                    state_n = S_HOLD;
                    cnt_n   = '0;
                end
            end
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_n = ALL_AT_ONCE ? S_RUN : S_SEQ;
                    rst_nxt = FIRST_RST;
                    cnt_n   = '0;
                    ch_n    = IW'(1);
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_SEQ: begin
                if (srst_req_i) begin
                    state_n = S_SRST;
                    rst_nxt = '1;
                    cnt_n   = '0;
                    ch_n    = '0;
                end else if (cnt == GAP_LAST) begin
                    for (int k = 0; k < P_NUM_CH; k++)
                        if (IW'(k) == ch_idx) rst_nxt[k] = 1'b0;
                    cnt_n = '0;
                    ch_n  = ch_idx + IW'(1);
                    if (ch_idx == LAST_CH) state_n = S_RUN;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_RUN: begin
                if (srst_req_i) begin
                    state_n = S_SRST;
                    rst_nxt = '1;
                    cnt_n   = '0;
                    ch_n    = '0;
                end
            end
            S_SRST: begin
                // A repeated request restarts the minimum assertion window.
                if (srst_req_i) begin
                    cnt_n = '0;
                end else if (cnt == SRST_LAST) begin
                    state_n = ALL_AT_ONCE ? S_RUN : S_SEQ;
                    rst_nxt = FIRST_RST;
                    cnt_n   = '0;
                    ch_n    = IW'(1);
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = S_OFF;
                rst_nxt = '1;
                cnt_n   = '0;
                ch_n    = '0;
            end
        endcase

        if (!en_i) begin
            state_n = S_OFF;
            rst_nxt = '1;
            cnt_n   = '0;
            ch_n    = '0;
        end

        done_n = (state_n == S_RUN);
        busy_n = (state_n == S_HOLD) || (state_n == S_SEQ) || (state_n == S_SRST);
    end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: default instance checked every cycle against expectations
// derived from the release schedule; two zero-gap variants checked around the first release.
module tb_rst_seq_gen;

    logic       clk_i = 1'b0;
    logic       rsth_i = 1'b1;
    logic       en_i = 1'b0;
    logic       srst_req_i = 1'b0;
    logic [3:0] rsth_o;
    logic       done_o, busy_o;
    logic [0:0] rsth1_o;
    logic       done1_o, busy1_o;
    logic [2:0] rsth3_o;
    logic       done3_o, busy3_o;

    always #5 clk_i = ~clk_i;

    rst_seq_gen dut (
        .clk_i(clk_i), .rsth_i(rsth_i), .en_i(en_i), .srst_req_i(srst_req_i),
        .rsth_o(rsth_o), .done_o(done_o), .busy_o(busy_o)
    );

    rst_seq_gen #(.P_NUM_CH(1), .P_CH_GAP(0)) dut1 (
        .clk_i(clk_i), .rsth_i(rsth_i), .en_i(en_i), .srst_req_i(srst_req_i),
        .rsth_o(rsth1_o), .done_o(done1_o), .busy_o(busy1_o)
    );

    rst_seq_gen #(.P_NUM_CH(3), .P_CH_GAP(0)) dut3 (
        .clk_i(clk_i), .rsth_i(rsth_i), .en_i(en_i), .srst_req_i(srst_req_i),
        .rsth_o(rsth3_o), .done_o(done3_o), .busy_o(busy3_o)
    );

    typedef struct packed {
        logic [3:0] rsth;
        logic       done;
        logic       busy;
    } exp_t;

    typedef struct packed {
        logic r, e, s;
        exp_t x;
    } vec_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    localparam exp_t HELD = '{rsth: 4'hF, done: 1'b0, busy: 1'b1};
    localparam exp_t IDLE = '{rsth: 4'hF, done: 1'b0, busy: 1'b0};

    // Expected outputs m edges after the ch0 release edge (16-cycle gap, 4 channels).
    function automatic exp_t exp_seq(input int m);
        int   n;
        exp_t x;
        n = m / 16 + 1;
        if (n > 4) n = 4;
        x.rsth = 4'hF << n;
        x.done = (n == 4);
        x.busy = (n != 4);
        return x;
    endfunction

    task automatic drive(input logic r, input logic e, input logic s, input exp_t x, input string tag);
        exp_t w;
        rsth_i = r; en_i = e; srst_req_i = s;
        sbq.push_back(x);
        @(posedge clk_i);
        #1;
        w = sbq.pop_front();
        checks++;
        if (rsth_o !== w.rsth || done_o !== w.done || busy_o !== w.busy) begin
            errors++;
            $display("FAIL %s @%0t: got rsth=%h done=%b busy=%b, want rsth=%h done=%b busy=%b",
                     tag, $time, rsth_o, done_o, busy_o, w.rsth, w.done, w.busy);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0t: got %h, want %h", tag, $time, got, want);
        end
    endtask

    task automatic hold_run(input int n, input string tag);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, HELD, tag);
    endtask

    task automatic seq_run(input int last, input string tag);
        for (int m = 0; m <= last; m++) drive(1'b0, 1'b1, 1'b0, exp_seq(m), tag);
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = '{r: 1, e: 0, s: 0, x: IDLE};
        vt[1] = '{r: 1, e: 0, s: 0, x: IDLE};
        vt[2] = '{r: 1, e: 0, s: 0, x: IDLE};
        vt[3] = '{r: 1, e: 1, s: 0, x: IDLE};
        vt[4] = '{r: 1, e: 1, s: 1, x: IDLE};
        vt[5] = '{r: 0, e: 0, s: 0, x: IDLE};
        vt[6] = '{r: 0, e: 0, s: 1, x: IDLE};
        vt[7] = '{r: 0, e: 1, s: 0, x: HELD};   // E0
        for (int i = 0; i < 8; i++) drive(vt[i].r, vt[i].e, vt[i].s, vt[i].x, "reset_tbl");

        // Test 1 + HOLD ignores a soft-reset request.
        hold_run(49, "hold1");
        drive(1'b0, 1'b1, 1'b1, HELD, "hold1_srst");
        hold_run(49, "hold1");
        chk("n1_pre_rsth", {7'd0, rsth1_o}, 8'h01);
        chk("n1_pre_stat", {6'd0, done1_o, busy1_o}, 8'h01);
        chk("n3_pre_rsth", {5'd0, rsth3_o}, 8'h07);
        drive(1'b0, 1'b1, 1'b0, exp_seq(0), "seq1");
        chk("n1_rel_rsth", {7'd0, rsth1_o}, 8'h00);
        chk("n1_rel_stat", {6'd0, done1_o, busy1_o}, 8'h02);
        chk("n3_rel_rsth", {5'd0, rsth3_o}, 8'h00);
        chk("n3_rel_stat", {6'd0, done3_o, busy3_o}, 8'h02);
        for (int m = 1; m <= 52; m++) drive(1'b0, 1'b1, 1'b0, exp_seq(m), "seq1");

        // Test 3: single soft-reset pulse in RUN.
        drive(1'b0, 1'b1, 1'b1, HELD, "srst3_T");
        hold_run(7, "srst3_wait");
        seq_run(50, "srst3_seq");

        // Test 4: repeated request restarts the window.
        drive(1'b0, 1'b1, 1'b1, HELD, "srst4_T");
        hold_run(4, "srst4_wait");
        drive(1'b0, 1'b1, 1'b1, HELD, "srst4_T5");
        hold_run(7, "srst4_wait2");
        seq_run(50, "srst4_seq");

        // Soft reset in mid-SEQ, then test 2 from a fresh enable.
        drive(1'b0, 1'b0, 1'b0, IDLE, "en_low_run");
        drive(1'b0, 1'b1, 1'b0, HELD, "en_E");
        hold_run(99, "hold2");
        seq_run(20, "seq2");
        drive(1'b0, 1'b1, 1'b1, HELD, "srst_mid");
        hold_run(7, "srst_mid_wait");
        seq_run(16, "srst_mid_seq");
        drive(1'b0, 1'b0, 1'b0, IDLE, "en_low_seq");
        drive(1'b0, 1'b0, 1'b1, IDLE, "off_srst");
        drive(1'b0, 1'b1, 1'b0, HELD, "en_E1");
        hold_run(99, "hold2b");
        seq_run(5, "seq2b");

        // Test 6: reset pulse mid-SEQ with enable held.
        drive(1'b1, 1'b1, 1'b0, IDLE, "rst6");
        drive(1'b0, 1'b1, 1'b0, HELD, "rst6_hold0");
        hold_run(99, "hold6");
        seq_run(50, "seq6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
